// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the round-robin packet-locked AXI-Stream switch.
// Arbiter state, TDEST range compare and the cyclic first-requester search.
package axis_switch_pkg;

  localparam int MAX_PORTS = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic dest_in_range(input logic [63:0] d,
                                         input logic [63:0] lo,
                                         input logic [63:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  // Returns {found, index} of the first requester at or after ptr, wrapping at n.
  function automatic logic [4:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [3:0] ptr,
                                         input int n);
    logic [4:0] res;
    int idx;
    res = '0;
    for (int o = 0; o < MAX_PORTS; o++) begin
      idx = int'(ptr) + o;
      if (idx >= n) idx = idx - n;
      if ((o < n) && !res[4] && req[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry register slice for one switch output; the input side sees only
// "full", so a full-rate stream survives a one-cycle stall without a bubble.
module axis_skid2
  import axis_switch_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ID_WIDTH-1:0]   i_id,
  input  logic [DEST_WIDTH-1:0] i_dest,
  input  logic                  i_last,
  output logic                  o_full,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ID_WIDTH-1:0]   o_id,
  output logic [DEST_WIDTH-1:0] o_dest,
  output logic                  o_last
);

  logic [DATA_WIDTH-1:0] r_data [2];
  logic [ID_WIDTH-1:0]   r_id   [2];
  logic [DEST_WIDTH-1:0] r_dest [2];
  logic [1:0]            r_last;
  logic                  r_wr;
  logic                  r_rd;
  logic [1:0]            r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign w_push  = i_valid && (r_cnt != 2'd2);
  assign w_pop   = (r_cnt != 2'd0) && i_ready;
  assign o_full  = (r_cnt == 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_data[r_rd];
  assign o_id    = r_id[r_rd];
  assign o_dest  = r_dest[r_rd];
  assign o_last  = r_last[r_rd];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= 2'd0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_data[r_wr] <= i_data;
      r_id[r_wr]   <= i_id;
      r_dest[r_wr] <= i_dest;
      r_last[r_wr] <= i_last;
    end
  end

endmodule

// File: rtl/axis_switch_rrobin_pkt.sv
// NSLAVES x NMASTERS AXI-Stream crossbar: per-master round-robin arbiter with
// packet locking, range-based TDEST decode with drop of unroutable packets.
module axis_switch_rrobin_pkt
  import axis_switch_pkg::*;
#(
  parameter int NSLAVES     = 2,
  parameter int NMASTERS    = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int HAS_ID      = 0,
  parameter int HAS_LAST    = 0,
  parameter int HAS_DEST    = 0,
  parameter int ID_WIDTH    = 1,
  parameter int DEST_WIDTH  = 1,
  parameter int DEST_BASE   = 0,
  parameter int DEST_STRIDE = 1,
  parameter int DEST_RANGE  = 0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NSLAVES-1:0]             s_valid,
  output logic [NSLAVES-1:0]             s_ready,
  input  logic [NSLAVES*DATA_WIDTH-1:0]  s_data,
  input  logic [NSLAVES*ID_WIDTH-1:0]    s_id,
  input  logic [NSLAVES*DEST_WIDTH-1:0]  s_dest,
  input  logic [NSLAVES-1:0]             s_last,
  output logic [NMASTERS-1:0]            m_valid,
  input  logic [NMASTERS-1:0]            m_ready,
  output logic [NMASTERS*DATA_WIDTH-1:0] m_data,
  output logic [NMASTERS*ID_WIDTH-1:0]   m_id,
  output logic [NMASTERS*DEST_WIDTH-1:0] m_dest,
  output logic [NMASTERS-1:0]            m_last,
  output logic [NSLAVES-1:0]             decerr
);

  localparam int CW = DEST_WIDTH + 5;

  logic                  r_en;
  logic [NSLAVES-1:0]    r_drop;
  arb_state_e            r_state     [NMASTERS];
  arb_state_e            w_state_nxt [NMASTERS];
  logic [3:0]            r_gnt       [NMASTERS];
  logic [3:0]            w_gnt_nxt   [NMASTERS];
  logic [3:0]            r_ptr       [NMASTERS];
  logic [3:0]            w_ptr_nxt   [NMASTERS];

  logic [3:0]            w_tgt  [NSLAVES];
  logic [NSLAVES-1:0]    w_hit;
  logic [NSLAVES-1:0]    w_busy;
  logic [NSLAVES-1:0]    w_free;
  logic [NSLAVES-1:0]    w_drop_start;
  logic [NSLAVES-1:0]    w_req  [NMASTERS];

  logic [NMASTERS-1:0]   w_gv;
  logic [3:0]            w_gi   [NMASTERS];
  logic [NMASTERS-1:0]   w_mv;
  logic [DATA_WIDTH-1:0] w_md   [NMASTERS];
  logic [ID_WIDTH-1:0]   w_mi   [NMASTERS];
  logic [DEST_WIDTH-1:0] w_mdst [NMASTERS];
  logic [NMASTERS-1:0]   w_ml;
  logic [NMASTERS-1:0]   w_lastb;
  logic [NMASTERS-1:0]   w_push;
  logic [NMASTERS-1:0]   w_full;

  // Held low from reset assertion until the first clock after release, so no
  // handshake or decode error can appear while the switch is being reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_en <= 1'b0;
    else          r_en <= 1'b1;
  end

  // Lowest-numbered master whose range holds TDEST wins; widened so no wrap.
  always_comb begin
    logic [CW-1:0] lo;
    logic [CW-1:0] hi;
    lo = '0;
    hi = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      w_hit[i] = 1'b0;
      w_tgt[i] = '0;
      if (HAS_DEST == 0) begin
        w_hit[i] = 1'b1;
      end else begin
        for (int k = NMASTERS - 1; k >= 0; k--) begin
          lo = CW'(DEST_BASE) + CW'(k) * CW'(DEST_STRIDE);
          hi = lo + CW'(DEST_RANGE);
          if (dest_in_range(64'(s_dest[i*DEST_WIDTH +: DEST_WIDTH]), 64'(lo), 64'(hi))) begin
            w_hit[i] = 1'b1;
            w_tgt[i] = 4'(k);
          end
        end
      end
    end
  end

  // A slave mid-packet is owned by exactly one locked master or by the drop path,
  // so only slaves at a packet boundary present a decoded request.
  always_comb begin
    w_busy = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      for (int i = 0; i < NSLAVES; i++) begin
        if ((r_state[k] == ARB_LOCKED) && (r_gnt[k] == 4'(i))) w_busy[i] = 1'b1;
      end
    end
  end

  assign w_free       = s_valid & ~w_busy & ~r_drop & {NSLAVES{r_en}};
  assign w_drop_start = w_free & ~w_hit;
  assign decerr       = w_drop_start;

  always_comb begin
    for (int k = 0; k < NMASTERS; k++) begin
      for (int i = 0; i < NSLAVES; i++) begin
        w_req[k][i] = w_free[i] && w_hit[i] && (w_tgt[i] == 4'(k));
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NMASTERS; k++) begin
        r_state[k] <= ARB_IDLE;
        r_gnt[k]   <= '0;
        r_ptr[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NMASTERS; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_gnt[k]   <= w_gnt_nxt[k];
        r_ptr[k]   <= w_ptr_nxt[k];
      end
    end
  end

  // Pointer moves one past the releasing slave so it becomes lowest priority.
  always_comb begin
    for (int k = 0; k < NMASTERS; k++) begin
      w_state_nxt[k] = r_state[k];
      w_gnt_nxt[k]   = r_gnt[k];
      w_ptr_nxt[k]   = r_ptr[k];
      if (w_push[k] && w_lastb[k]) begin
        w_state_nxt[k] = ARB_IDLE;
        w_ptr_nxt[k]   = (w_gi[k] == 4'(NSLAVES - 1)) ? 4'd0 : w_gi[k] + 4'd1;
      end else if (w_push[k] && (r_state[k] == ARB_IDLE)) begin
        w_state_nxt[k] = ARB_LOCKED;
        w_gnt_nxt[k]   = w_gi[k];
      end
    end
  end

  always_comb begin
    logic [4:0] pick;
    pick = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      pick = rr_pick(MAX_PORTS'(w_req[k]), r_ptr[k], NSLAVES);
      if (r_state[k] == ARB_LOCKED) begin
        w_gv[k] = 1'b1;
        w_gi[k] = r_gnt[k];
      end else begin
        w_gv[k] = pick[4];
        w_gi[k] = pick[3:0];
      end
      w_mv[k]   = 1'b0;
      w_md[k]   = '0;
      w_mi[k]   = '0;
      w_mdst[k] = '0;
      w_ml[k]   = 1'b0;
      for (int i = 0; i < NSLAVES; i++) begin
        if (w_gi[k] == 4'(i)) begin
          w_mv[k]   = s_valid[i];
          w_md[k]   = s_data[i*DATA_WIDTH +: DATA_WIDTH];
          w_mi[k]   = (HAS_ID != 0) ? s_id[i*ID_WIDTH +: ID_WIDTH] : '0;
          w_mdst[k] = s_dest[i*DEST_WIDTH +: DEST_WIDTH];
          w_ml[k]   = s_last[i];
        end
      end
      w_lastb[k] = (HAS_LAST != 0) ? w_ml[k] : 1'b1;
      w_push[k]  = w_gv[k] && w_mv[k] && !w_full[k] && r_en;
    end
  end

  always_comb begin
    for (int i = 0; i < NSLAVES; i++) begin
      s_ready[i] = w_drop_start[i] || (r_drop[i] && r_en);
      for (int k = 0; k < NMASTERS; k++) begin
        if (w_gv[k] && (w_gi[k] == 4'(i)) && !w_full[k] && r_en) s_ready[i] = 1'b1;
      end
    end
  end

  // Unroutable packets are swallowed up to and including their last beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_drop <= '0;
    end else begin
      for (int i = 0; i < NSLAVES; i++) begin
        if (w_drop_start[i]) begin
          r_drop[i] <= (HAS_LAST != 0) && !s_last[i];
        end else if (r_drop[i] && s_valid[i] && s_last[i]) begin
          r_drop[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NMASTERS; g++) begin : g_skid
    axis_skid2 #(
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .DEST_WIDTH (DEST_WIDTH)
    ) u_skid (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_valid (w_push[g]),
      .i_data  (w_md[g]),
      .i_id    (w_mi[g]),
      .i_dest  (w_mdst[g]),
      .i_last  (w_lastb[g]),
      .o_full  (w_full[g]),
      .o_valid (m_valid[g]),
      .i_ready (m_ready[g]),
      .o_data  (m_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_id    (m_id[g*ID_WIDTH +: ID_WIDTH]),
      .o_dest  (m_dest[g*DEST_WIDTH +: DEST_WIDTH]),
      .o_last  (m_last[g])
    );
  end

endmodule

// File: tb/tb_axis_switch_rrobin_pkt.sv
// Directed bench for the 2x2 packet switch: masters own TDEST 4..5 and 8..9.
module tb_axis_switch_rrobin_pkt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_valid, s_ready, s_last, decerr;
  logic [31:0] s_data;
  logic [3:0]  s_id;
  logic [7:0]  s_dest;
  logic [1:0]  m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_id;
  logic [7:0]  m_dest;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int sacc [2] = '{0, 0};
  int dec  [2] = '{0, 0};
  logic [22:0] q0 [$];
  logic [22:0] q1 [$];
  int c0 [$];
  int c1 [$];
  logic [22:0] eq [$];

  always #5 clk = ~clk;

  axis_switch_rrobin_pkt #(
    .NSLAVES(2), .NMASTERS(2), .DATA_WIDTH(16), .HAS_ID(1), .HAS_LAST(1),
    .HAS_DEST(1), .ID_WIDTH(2), .DEST_WIDTH(4), .DEST_BASE(4),
    .DEST_STRIDE(4), .DEST_RANGE(1)
  ) dut (
    .aclk(clk), .aresetn(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_id(s_id),
    .s_dest(s_dest), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
    .m_dest(m_dest), .m_last(m_last), .decerr(decerr)
  );

  function automatic logic [22:0] pk(input logic [1:0] id, input logic [3:0] d,
                                     input logic l, input logic [15:0] v);
    return {id, d, l, v};
  endfunction

  function automatic logic [22:0] obs(input int k);
    return {m_id[k*2 +: 2], m_dest[k*4 +: 4], m_last[k], m_data[k*16 +: 16]};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (s_valid[i] && s_ready[i]) sacc[i]++;
        if (decerr[i]) dec[i]++;
      end
      if (m_valid[0] && m_ready[0]) begin q0.push_back(obs(0)); c0.push_back(cyc); end
      if (m_valid[1] && m_ready[1]) begin q1.push_back(obs(1)); c1.push_back(cyc); end
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input int n, input logic [3:0] d0, input logic [3:0] dn,
                      input logic [15:0] base, input bit every);
    for (int b = 0; b < n; b++) begin
      int t;
      t = 0;
      s_valid[s]         = 1'b1;
      s_data[s*16 +: 16] = base + 16'(b);
      s_dest[s*4 +: 4]   = (b == 0) ? d0 : dn;
      s_id[s*2 +: 2]     = 2'(s);
      s_last[s]          = every || (b == n - 1);
      @(negedge clk);
      while (!s_ready[s] && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) chk_eq($sformatf("send%0d_timeout", s), 64'd1, 64'd0);
      @(posedge clk);
      #1;
    end
    s_valid[s] = 1'b0;
    s_last[s]  = 1'b0;
  endtask

  task automatic cmp_q(input int k, input string tag);
    int n;
    n = (k == 0) ? q0.size() : q1.size();
    chk_eq({tag, "_len"}, 64'(n), 64'(eq.size()));
    for (int i = 0; i < eq.size(); i++) begin
      logic [22:0] g;
      g = '1;
      if (i < n) g = (k == 0) ? q0[i] : q1[i];
      chk_eq($sformatf("%s_%0d", tag, i), 64'(g), 64'(eq[i]));
    end
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); c0.delete(); c1.delete(); eq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0s, d1s;
    time t0;
    rst_n = 1'b0;
    s_valid = 2'b11; s_last = 2'b00; s_data = '0; s_id = '0;
    s_dest = {4'd7, 4'd7};
    m_ready = 2'b11;
    #3;
    chk_eq("rst_m_valid", 64'(m_valid), 64'd0);
    chk_eq("rst_s_ready", 64'(s_ready), 64'd0);
    chk_eq("rst_decerr", 64'(decerr), 64'd0);
    #20;
    chk_eq("rst_hold_s_ready", 64'(s_ready), 64'd0);
    s_valid = 2'b00;
    #4 rst_n = 1'b1;
    step();
    step();
    chk_eq("idle_m_valid", 64'(m_valid), 64'd0);

    // Round robin between single-beat packets on one master
    clear_q();
    fork
      send(0, 8, 4'd5, 4'd5, 16'h0100, 1'b1);
      send(1, 8, 4'd4, 4'd4, 16'h0200, 1'b1);
    join
    repeat (3) step();
    for (int b = 0; b < 8; b++) begin
      eq.push_back(pk(2'd0, 4'd5, 1'b1, 16'h0100 + 16'(b)));
      eq.push_back(pk(2'd1, 4'd4, 1'b1, 16'h0200 + 16'(b)));
    end
    cmp_q(0, "rr");
    chk_eq("rr_span", 64'((c0.size() == 16) ? c0[15] - c0[0] : -1), 64'd15);
    chk_eq("rr_m1_idle", 64'(q1.size()), 64'd0);

    // Packet lock: no interleave, mid-packet TDEST change ignored
    clear_q();
    fork
      send(0, 4, 4'd5, 4'd8, 16'h0300, 1'b0);
      send(1, 2, 4'd4, 4'd4, 16'h0400, 1'b0);
    join
    repeat (3) step();
    eq.push_back(pk(2'd0, 4'd5, 1'b0, 16'h0300));
    eq.push_back(pk(2'd0, 4'd8, 1'b0, 16'h0301));
    eq.push_back(pk(2'd0, 4'd8, 1'b0, 16'h0302));
    eq.push_back(pk(2'd0, 4'd8, 1'b1, 16'h0303));
    eq.push_back(pk(2'd1, 4'd4, 1'b0, 16'h0400));
    eq.push_back(pk(2'd1, 4'd4, 1'b1, 16'h0401));
    cmp_q(0, "lock");
    chk_eq("lock_m1_idle", 64'(q1.size()), 64'd0);

    // Two masters concurrently at full rate
    clear_q();
    fork
      send(0, 4, 4'd5, 4'd5, 16'h0350, 1'b0);
      send(1, 4, 4'd8, 4'd9, 16'h0450, 1'b0);
    join
    repeat (3) step();
    for (int b = 0; b < 4; b++) eq.push_back(pk(2'd0, 4'd5, b == 3, 16'h0350 + 16'(b)));
    cmp_q(0, "par_m0");
    eq.delete();
    eq.push_back(pk(2'd1, 4'd8, 1'b0, 16'h0450));
    for (int b = 1; b < 4; b++) eq.push_back(pk(2'd1, 4'd9, b == 3, 16'h0450 + 16'(b)));
    cmp_q(1, "par_m1");
    chk_eq("par_span0", 64'((c0.size() == 4) ? c0[3] - c0[0] : -1), 64'd3);
    chk_eq("par_span1", 64'((c1.size() == 4) ? c1[3] - c1[0] : -1), 64'd3);
    chk_eq("par_same_start", 64'((c0.size() > 0 && c1.size() > 0) ? c0[0] - c1[0] : -1), 64'd0);

    // Decode-error drop: gap TDEST 7 (3 beats) and out-of-range TDEST 10
    clear_q();
    a0 = sacc[0]; d0s = dec[0]; d1s = dec[1];
    t0 = $time;
    fork
      send(0, 3, 4'd7, 4'd5, 16'h0600, 1'b0);
      send(1, 1, 4'd10, 4'd10, 16'h0610, 1'b0);
    join
    chk_eq("drop_time", 64'($time - t0), 64'd30);
    repeat (3) step();
    chk_eq("drop_acc", 64'(sacc[0] - a0), 64'd3);
    chk_eq("drop_decerr0", 64'(dec[0] - d0s), 64'd1);
    chk_eq("drop_decerr1", 64'(dec[1] - d1s), 64'd1);
    chk_eq("drop_no_m0", 64'(q0.size()), 64'd0);
    chk_eq("drop_no_m1", 64'(q1.size()), 64'd0);

    // Backpressure: skid absorbs exactly two beats
    clear_q();
    a0 = sacc[0];
    fork
      send(0, 6, 4'd5, 4'd5, 16'h0500, 1'b0);
      begin
        m_ready[0] = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk_eq("bp_acc", 64'(sacc[0] - a0), 64'd2);
        chk_eq("bp_s_ready", 64'(s_ready[0]), 64'd0);
        chk_eq("bp_m_valid", 64'(m_valid[0]), 64'd1);
        chk_eq("bp_m_data", 64'(m_data[15:0]), 64'h0500);
        @(posedge clk);
        #1;
        m_ready[0] = 1'b1;
      end
    join
    repeat (4) step();
    for (int b = 0; b < 6; b++) eq.push_back(pk(2'd0, 4'd5, b == 5, 16'h0500 + 16'(b)));
    cmp_q(0, "bp");

    // Asynchronous reset mid-packet, then pointer back at slave 0
    s_valid[0] = 1'b1; s_dest[3:0] = 4'd5; s_id[1:0] = 2'd0; s_last[0] = 1'b0;
    s_data[15:0] = 16'h0600;
    step();
    s_data[15:0] = 16'h0601;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_m_valid", 64'(m_valid), 64'd0);
    chk_eq("arst_s_ready", 64'(s_ready), 64'd0);
    s_valid = 2'b00;
    #10 rst_n = 1'b1;
    step();
    clear_q();
    fork
      send(0, 1, 4'd5, 4'd5, 16'h0700, 1'b0);
      send(1, 1, 4'd5, 4'd5, 16'h0701, 1'b0);
    join
    repeat (3) step();
    eq.push_back(pk(2'd0, 4'd5, 1'b1, 16'h0700));
    eq.push_back(pk(2'd1, 4'd5, 1'b1, 16'h0701));
    cmp_q(0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
